// File: rtl/dpram_port_arb.sv
// dpram_port_arb
//   Shares one port of a dual-port RAM between NREQ requesters. Only one access
//   is in flight at a time. The RAM port is clocked by clk_sys and has a
//   registered read. Read data comes back on rdata together with a one-cycle,
//   per-requester ack pulse.
//
//   Arbitration is round-robin by default. Define DPRAM_ARB_FIXED_PRIO_EN to get
//   fixed priority instead, where the lowest index wins. In both modes, a
//   requester acked on one edge is not eligible on the next edge.
//
// Ports:
//   clk_sys      system clock (also clocks the RAM port)
//   reset        asynchronous, active-high reset
//   req          per-requester request level, held until ack
//   we           per-requester write enable (1 = write)
//   addr, wdata  packed per-requester address / write data (slice i = requester i)
//   ack          one-cycle completion pulse, at most one bit set
//   rdata        read data, valid with ack, otherwise held
//   ram_addr, ram_wdata, ram_wren, ram_byteena  registered RAM port controls
//   ram_q        RAM read data (registered inside the RAM)
module dpram_port_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NREQ   = 3
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     ram_wren,
  output logic                     ram_byteena,
  input  logic [DATA_W-1:0]        ram_q
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   cur;
  logic               cur_we;
  logic [NREQ-1:0]    excl;
  logic [NREQ-1:0]    cur_oh;
  logic [NREQ-1:0]    elig;
  logic               found;
  logic [IDX_W-1:0]   win;

`ifndef DPRAM_ARB_FIXED_PRIO_EN
  localparam int unsigned NREQ_U = NREQ;
  logic [IDX_W-1:0]   rr_last;
  logic [IDX_W-1:0]   base;
  int unsigned        idx;
  logic [IDX_W-1:0]   idx_v;
`endif

  always_comb begin
    cur_oh = NREQ'(1) << cur;
    // The requester completing in RESP is excluded from the re-arbitration on that same edge.
    elig = req & ~excl;
    if (state == RESP) elig = elig & ~cur_oh;
    found = 1'b0;
    win   = '0;
`ifdef DPRAM_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && elig[IDX_W'(i)]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
`else
    // In RESP, rr_last is updated to cur on this same edge, so the search starts from cur.
    base  = (state == RESP) ? cur : rr_last;
    idx   = 0;
    idx_v = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(base) + 32'd1 + i;
      // NREQ need not be a power of two, so wrap by compare-and-subtract.
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      idx_v = IDX_W'(idx);
      if (!found && elig[idx_v]) begin
        found = 1'b1;
        win   = idx_v;
      end
    end
`endif
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ack         <= '0;
      rdata       <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_wren    <= 1'b0;
      ram_byteena <= 1'b0;
      cur         <= '0;
      cur_we      <= 1'b0;
      excl        <= '0;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
      rr_last     <= IDX_W'(NREQ - 1);
`endif
    end else begin
      ack  <= '0;
      excl <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            ram_addr    <= addr[win*ADDR_W +: ADDR_W];
            ram_wdata   <= wdata[win*DATA_W +: DATA_W];
            ram_wren    <= we[win];
            ram_byteena <= 1'b1;
            cur         <= win;
            cur_we      <= we[win];
            state       <= ACCESS;
          end else begin
            ram_wren    <= 1'b0;
            ram_byteena <= 1'b0;
          end
        end
        ACCESS: begin
          ram_wren <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          if (!cur_we) rdata <= ram_q;
          ack  <= cur_oh;
          excl <= cur_oh;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
          rr_last <= cur;
`endif
          if (found) begin
            ram_addr    <= addr[win*ADDR_W +: ADDR_W];
            ram_wdata   <= wdata[win*DATA_W +: DATA_W];
            ram_wren    <= we[win];
            ram_byteena <= 1'b1;
            cur         <= win;
            cur_we      <= we[win];
            state       <= ACCESS;
          end else begin
            ram_byteena <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_arb.sv
module tb_dpram_port_arb;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [2:0]  req     = '0;
  logic [2:0]  we      = '0;
  logic [23:0] addr    = '0;
  logic [23:0] wdata   = '0;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_wren;
  logic        ram_byteena;
  logic [7:0]  ram_q;
  logic        preload = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  dpram_port_arb #(.ADDR_W(8), .DATA_W(8), .NREQ(3)) dut (
    .clk_sys(clk_sys), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_byteena(ram_byteena),
    .ram_q(ram_q)
  );

  // RAM port model: registered read (old data on a same-edge write).
  logic [7:0] mem [256];
  always @(posedge clk_sys) begin
    if (preload) mem[8'h10] <= 8'hA5;
    else if (ram_wren && ram_byteena) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0] ack;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: every ack pops the oldest expectation.
  always @(negedge clk_sys) begin
    exp_t e;
    if (!reset && ack != 3'b000) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_who", 32'(ack), 32'(e.ack));
        chk("rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  typedef struct {
    int         idx;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  task automatic drive(input int idx, input bit w, input logic [7:0] a, input logic [7:0] d);
    req[idx]         = 1'b1;
    we[idx]          = w;
    addr[idx*8 +: 8]  = a;
    wdata[idx*8 +: 8] = d;
  endtask

  task automatic do_txn(input int idx, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    int lat;
    bit got, wren_seen;
    exp_t e;
    @(negedge clk_sys);
    drive(idx, w, a, d);
    e.ack = 3'(1 << idx);
    e.rdata = exp;
    sb.push_back(e);
    lat = 0; got = 0; wren_seen = 0;
    while (!got && lat < 10) begin
      @(negedge clk_sys);
      lat++;
      if (ram_wren) wren_seen = 1;
      if (ack[idx]) got = 1;
    end
    req[idx] = 1'b0;
    chk("ack_latency", 32'(got ? lat : 99), 32'd3);
    chk("ram_wren_use", 32'(wren_seen), 32'(w));
  endtask

  initial begin
    vec_t tbl[8];
    int   times[8];
    int   n, cyc, cnt;
    exp_t e;
    logic [7:0] exp_seq[7];

    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   times[8];
    int   n, cyc, cnt;
    exp_t e;
    logic [7:0] exp_seq[7];

    tbl[0] = '{1, 1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[1] = '{0, 1'b1, 8'h20, 8'h3C, 8'hA5};
    tbl[2] = '{2, 1'b0, 8'h20, 8'h00, 8'h3C};
    tbl[3] = '{2, 1'b1, 8'hFF, 8'h81, 8'h3C};
    tbl[4] = '{0, 1'b0, 8'hFF, 8'h00, 8'h81};
    tbl[5] = '{1, 1'b1, 8'h00, 8'h55, 8'h81};
    tbl[6] = '{1, 1'b0, 8'h00, 8'h00, 8'h55};
    tbl[7] = '{0, 1'b0, 8'h10, 8'h00, 8'hA5};

    // Reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    chk("rst_ram_byteena", 32'(ram_byteena), 32'd0);
    preload = 1'b0;
    reset = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 8; i++)
      do_txn(tbl[i].idx, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);
    repeat (3) @(negedge clk_sys);
    chk("table_drained", 32'(sb.size()), 32'd0);

    // Contention from reset: expected round-robin 0,1,2,0,1,2, then 0 again
    // because that access is already in flight when the requests drop.
    @(negedge clk_sys);
    reset = 1'b1;
    drive(0, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b0, 8'h20, 8'h00);
    drive(2, 1'b0, 8'hFF, 8'h00);
    exp_seq = '{8'hA5, 8'h3C, 8'h81, 8'hA5, 8'h3C, 8'h81, 8'hA5};
    for (int i = 0; i < 7; i++) begin
      e.ack = 3'(1 << (i % 3));
      e.rdata = exp_seq[i];
      sb.push_back(e);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    n = 0; cyc = 0;
    while (n < 7 && cyc < 40) begin
      @(negedge clk_sys);
      cyc++;
      if (ack != 3'b000) begin
        times[n] = cyc;
        n++;
        if (n == 6) req = '0;
      end
    end
    req = '0;
    chk("contention_acks", 32'(n), 32'd7);
    chk("contention_first_latency", 32'(n > 0 ? times[0] : 99), 32'd3);
    for (int i = 1; i < 7; i++)
      if (i < n) chk("contention_spacing", 32'(times[i] - times[i-1]), 32'd2);
    repeat (4) @(negedge clk_sys);
    chk("contention_drained", 32'(sb.size()), 32'd0);

    // Stale request: requester 1 holds req one cycle past its ack
    @(negedge clk_sys);
    drive(1, 1'b0, 8'h00, 8'h00);
    e.ack = 3'b010;
    e.rdata = 8'h55;
    sb.push_back(e);
    cnt = 0; cyc = 0;
    while (cnt == 0 && cyc < 10) begin
      @(negedge clk_sys);
      cyc++;
      if (ack[1]) cnt++;
    end
    @(negedge clk_sys);
    if (ack[1]) cnt++;
    req[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      if (ack[1]) cnt++;
    end
    chk("stale_ack_count", 32'(cnt), 32'd1);

    // Reset asserted while the access is in ACCESS
    @(negedge clk_sys);
    drive(2, 1'b1, 8'h30, 8'h77);
    @(negedge clk_sys);
    chk("midrst_in_access", 32'(ram_byteena), 32'd1);
    reset = 1'b1;
    req = '0;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("midrst_ram_wren", 32'(ram_wren), 32'd0);
    chk("midrst_ram_byteena", 32'(ram_byteena), 32'd0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("midrst_no_ack", 32'(ack), 32'd0);
    do_txn(2, 1'b0, 8'h20, 8'h00, 8'h3C);
    repeat (3) @(negedge clk_sys);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
